// File: rtl/ddr_write_scheduler.sv
// AXI4 write-burst scheduler: drains full bursts from a show-ahead word FIFO into a
// circular DDR region, one INCR burst at a time, collecting each write response.
module ddr_write_scheduler #(
   parameter int              WORD_WIDTH   = 256,
   parameter int              ADDR_WIDTH   = 32,
   parameter int              LEVEL_WIDTH  = 8,
   parameter int              BURST_LEN    = 4,
   parameter longint unsigned BASE_ADDR    = 0,
   parameter longint unsigned REGION_BYTES = 4096
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [LEVEL_WIDTH-1:0]    fifo_level,
   input  logic [WORD_WIDTH-1:0]     fifo_data,
   output logic                      fifo_rd_en,
   output logic [ADDR_WIDTH-1:0]     m_awaddr,
   output logic [7:0]                m_awlen,
   output logic [2:0]                m_awsize,
   output logic [1:0]                m_awburst,
   output logic                      m_awvalid,
   input  logic                      m_awready,
   output logic [WORD_WIDTH-1:0]     m_wdata,
   output logic [WORD_WIDTH/8-1:0]   m_wstrb,
   output logic                      m_wlast,
   output logic                      m_wvalid,
   input  logic                      m_wready,
   input  logic [1:0]                m_bresp,
   input  logic                      m_bvalid,
   output logic                      m_bready,
   output logic                      busy,
   output logic                      err,
   output logic [15:0]               burst_count
);

   // state | meaning
   // IDLE  | waiting for enable and a full burst in the FIFO
   // ADDR  | presenting the burst address on AW
   // DATA  | streaming BURST_LEN beats on W
   // RESP  | waiting for the B response
   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   localparam logic [ADDR_WIDTH-1:0]  BASE        = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0]  BURST_BYTES = ADDR_WIDTH'(BURST_LEN * (WORD_WIDTH / 8));
   localparam logic [ADDR_WIDTH-1:0]  REGION_END  = ADDR_WIDTH'(BASE_ADDR + REGION_BYTES);
   localparam logic [LEVEL_WIDTH-1:0] LEVEL_MIN   = LEVEL_WIDTH'(BURST_LEN);
   localparam logic [4:0]             BEAT_LAST   = 5'(BURST_LEN - 1);

   state_t                  state_q, state_d;
   logic [4:0]              beat_cnt_q, beat_cnt_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic                    err_q, err_d;
   logic [15:0]             burst_count_q, burst_count_d;
   logic [ADDR_WIDTH-1:0]   addr_inc;
   logic [ADDR_WIDTH-1:0]   addr_next;

   // Region size is a whole number of bursts, so an exact-equality wrap is sufficient.
   assign addr_inc  = awaddr_q + BURST_BYTES;
   assign addr_next = (addr_inc == REGION_END) ? BASE : addr_inc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         beat_cnt_q    <= '0;
         awaddr_q      <= BASE;
         err_q         <= 1'b0;
         burst_count_q <= '0;
      end else begin
         state_q       <= state_d;
         beat_cnt_q    <= beat_cnt_d;
         awaddr_q      <= awaddr_d;
         err_q         <= err_d;
         burst_count_q <= burst_count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      beat_cnt_d    = beat_cnt_q;
      awaddr_d      = awaddr_q;
      err_d         = err_q;
      burst_count_d = burst_count_q;
      case (state_q)
         IDLE: if (enable && (fifo_level >= LEVEL_MIN)) state_d = ADDR;
         ADDR: if (m_awready) state_d = DATA;
         DATA: begin
            if (m_wready) begin
               if (beat_cnt_q == BEAT_LAST) begin
                  beat_cnt_d = '0;
                  state_d    = RESP;
               end else begin
                  beat_cnt_d = beat_cnt_q + 5'd1;
               end
            end
         end
         RESP: begin
            if (m_bvalid) begin
               err_d         = err_q | (m_bresp != 2'b00);
               burst_count_d = burst_count_q + 16'd1;
               awaddr_d      = addr_next;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign m_awvalid   = (state_q == ADDR);
   assign m_wvalid    = (state_q == DATA);
   assign m_bready    = (state_q == RESP);
   assign fifo_rd_en  = m_wvalid && m_wready;
   assign m_wlast     = m_wvalid && (beat_cnt_q == BEAT_LAST);
   assign m_awaddr    = awaddr_q;
   assign m_awlen     = 8'(BURST_LEN - 1);
   assign m_awsize    = 3'($clog2(WORD_WIDTH / 8));
   assign m_awburst   = 2'b01;
   assign m_wdata     = fifo_data;
   assign m_wstrb     = '1;
   assign busy        = (state_q != IDLE);
   assign err         = err_q;
   assign burst_count = burst_count_q;

endmodule
